jesd204b_rx_slide_ctrl: RTL and testbench

JESD204B_RX_SLIDE_CTRL -- requirements
Module: jesd204b_rx_slide_ctrl

---
 rtl/jesd204b_rx_pkg.sv | 29 ++
 rtl/jesd204b_rx_slide_ctrl_if.sv | 24 ++
 rtl/jesd204b_lmfc_gen.sv | 62 ++++++
 rtl/jesd204b_rx_slide_ctrl.sv | 126 ++++++++++++
 tb/tb_jesd204b_rx_slide_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jesd204b_rx_pkg.sv
// Shared types and constants for the JESD204B receive slide/alignment controller.
package jesd204b_rx_pkg;

    localparam int unsigned SYM_W       = 10;
    localparam int unsigned WORD_W      = 2 * SYM_W;
    localparam int unsigned COMMA_CNT_W = 3;

    localparam logic [SYM_W-1:0]       K28_5_RDN    = 10'b0101111100;
    localparam logic [SYM_W-1:0]       K28_5_RDP    = 10'b1010000011;
    localparam logic [COMMA_CNT_W-1:0] COMMA_THRESH = 3'd4;

    typedef enum logic [1:0] {
        CGS_CHECK = 2'd0,
        CGS_WAIT  = 2'd1,
        SYNC_WAIT = 2'd2,
        DATA      = 2'd3
    } rx_state_e;

    // sym0 is the first-received symbol of the parallel word
    typedef struct packed {
        logic [SYM_W-1:0] sym1;
        logic [SYM_W-1:0] sym0;
    } rx_word_t;

    function automatic logic is_comma(input logic [SYM_W-1:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

endpackage

// File: rtl/jesd204b_rx_slide_ctrl_if.sv
// Lane-side bundle: transceiver data/SYSREF in, slide request, SYNC~ and user data out.
interface jesd204b_rx_slide_ctrl_if;
    import jesd204b_rx_pkg::*;

    rx_word_t i_rx_data;
    logic     i_sysref;
    logic     o_rxslide;
    logic     o_nsync;
    rx_word_t o_data;
    logic     o_data_valid;
    logic     o_lmfc;
    logic     o_aligned;

    modport master (
        output i_rx_data, i_sysref,
        input  o_rxslide, o_nsync, o_data, o_data_valid, o_lmfc, o_aligned
    );

    modport slave (
        input  i_rx_data, i_sysref,
        output o_rxslide, o_nsync, o_data, o_data_valid, o_lmfc, o_aligned
    );

endinterface

// File: rtl/jesd204b_lmfc_gen.sv
// LMFC counter with SYSREF rising-edge realignment.
// JESD_RX_SYSREF_REALIGN_EN: every SYSREF edge realigns; otherwise only the first after reset.
module jesd204b_lmfc_gen #(
    parameter int unsigned FRAME_SIZE     = 1,
    parameter int unsigned FMLC_NUM       = 8,
    parameter int unsigned FMLC_CNT_WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sysref,
    output logic o_lmfc,
    output logic o_lmfc_c,
    output logic o_sysref_seen,
    output logic o_sysref_seen_c
);

    localparam int unsigned LMFC_CLKS = (FRAME_SIZE * FMLC_NUM) / 2;

    generate
        if (((FRAME_SIZE * FMLC_NUM) % 2) != 0) begin : g_odd_fk
            $error("jesd204b_lmfc_gen: FRAME_SIZE*FMLC_NUM must be even");
        end
    endgenerate

    logic                      sysref_q;
    logic                      sysref_edge;
    logic                      realign;
    logic [FMLC_CNT_WIDTH-1:0] lmfc_cnt;
    logic [FMLC_CNT_WIDTH-1:0] lmfc_cnt_nxt;

    // Realignment load takes priority over the natural wrap
    always_comb begin
        sysref_edge = i_sysref & ~sysref_q;
`ifdef JESD_RX_SYSREF_REALIGN_EN
        realign     = sysref_edge;
`else
        realign     = sysref_edge & ~o_sysref_seen;
`endif
        if (realign || (lmfc_cnt == FMLC_CNT_WIDTH'(LMFC_CLKS - 1))) begin
            lmfc_cnt_nxt = '0;
        end else begin
            lmfc_cnt_nxt = lmfc_cnt + FMLC_CNT_WIDTH'(1);
        end
        o_lmfc_c        = (lmfc_cnt_nxt == '0);
        o_sysref_seen_c = o_sysref_seen | sysref_edge;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sysref_q      <= 1'b0;
            lmfc_cnt      <= '0;
            o_lmfc        <= 1'b0;
            o_sysref_seen <= 1'b0;
        end else begin
            sysref_q      <= i_sysref;
            lmfc_cnt      <= lmfc_cnt_nxt;
            o_lmfc        <= o_lmfc_c;
            o_sysref_seen <= o_sysref_seen_c;
        end
    end

endmodule

// File: rtl/jesd204b_rx_slide_ctrl.sv
// JESD204B RX comma alignment via bit-slip, code-group sync and LMFC-timed SYNC~ release.
// JESD_RX_SYSREF_REALIGN_EN: realign LMFC on every SYSREF edge (default: first edge only).
module jesd204b_rx_slide_ctrl
    import jesd204b_rx_pkg::*;
#(
    parameter int unsigned FRAME_SIZE     = 1,
    parameter int unsigned FMLC_NUM       = 8,
    parameter int unsigned SLIDE_WAIT     = 32,
    parameter int unsigned FMLC_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    jesd204b_rx_slide_ctrl_if.slave  rx_if
);

    localparam int unsigned WAIT_W = (SLIDE_WAIT > 1) ? $clog2(SLIDE_WAIT) : 1;

    rx_state_e              state;
    logic [COMMA_CNT_W-1:0] comma_cnt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   rxslide;
    logic                   nsync;
    rx_word_t               data_q;
    logic                   data_valid;
    logic                   aligned;
    logic                   lmfc;
    logic                   lmfc_c;
    logic                   sysref_seen;
    logic                   sysref_seen_c;
    logic                   lo_comma;
    logic                   both_comma;

    jesd204b_lmfc_gen #(
        .FRAME_SIZE     (FRAME_SIZE),
        .FMLC_NUM       (FMLC_NUM),
        .FMLC_CNT_WIDTH (FMLC_CNT_WIDTH)
    ) u_lmfc_gen (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_sysref        (rx_if.i_sysref),
        .o_lmfc          (lmfc),
        .o_lmfc_c        (lmfc_c),
        .o_sysref_seen   (sysref_seen),
        .o_sysref_seen_c (sysref_seen_c)
    );

    always_comb begin
        lo_comma   = is_comma(rx_if.i_rx_data.sym0);
        both_comma = lo_comma & is_comma(rx_if.i_rx_data.sym1);
    end

    // Link FSM; the release decision uses next-cycle LMFC so SYNC~ rises with the o_lmfc pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= CGS_CHECK;
            comma_cnt  <= '0;
            wait_cnt   <= '0;
            rxslide    <= 1'b0;
            nsync      <= 1'b0;
            data_q     <= '0;
            data_valid <= 1'b0;
            aligned    <= 1'b0;
        end else begin
            rxslide <= 1'b0;
            data_q  <= rx_if.i_rx_data;
            unique case (state)
                CGS_CHECK: begin
                    if (!lo_comma) begin
                        rxslide   <= 1'b1;
                        comma_cnt <= '0;
                        wait_cnt  <= '0;
                        state     <= CGS_WAIT;
                    end else if (both_comma) begin
                        if (comma_cnt == COMMA_THRESH - 3'd1) begin
                            comma_cnt <= '0;
                            aligned   <= 1'b1;
                            state     <= SYNC_WAIT;
                        end else begin
                            comma_cnt <= comma_cnt + 3'd1;
                        end
                    end else begin
                        comma_cnt <= '0;
                    end
                end
                CGS_WAIT: begin
                    if (wait_cnt == WAIT_W'(SLIDE_WAIT - 1)) begin
                        state <= CGS_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                SYNC_WAIT: begin
                    if (lmfc_c && sysref_seen_c) begin
                        nsync      <= 1'b1;
                        data_valid <= 1'b1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (both_comma) begin
                        if (comma_cnt == COMMA_THRESH - 3'd1) begin
                            comma_cnt  <= '0;
                            nsync      <= 1'b0;
                            data_valid <= 1'b0;
                            aligned    <= 1'b0;
                            state      <= CGS_CHECK;
                        end else begin
                            comma_cnt <= comma_cnt + 3'd1;
                        end
                    end else begin
                        comma_cnt <= '0;
                    end
                end
                default: state <= CGS_CHECK;
            endcase
        end
    end

    assign rx_if.o_rxslide    = rxslide;
    assign rx_if.o_nsync      = nsync;
    assign rx_if.o_data       = data_q;
    assign rx_if.o_data_valid = data_valid;
    assign rx_if.o_lmfc       = lmfc;
    assign rx_if.o_aligned    = aligned;

endmodule

// File: tb/tb_jesd204b_rx_slide_ctrl.sv
// Randomized bench for jesd204b_rx_slide_ctrl against a cycle-stamped behavioural link model.
module tb_jesd204b_rx_slide_ctrl;

    localparam int        SLIDE_WAIT = 32;
    localparam int        LMFC_CLKS  = 4;
    localparam logic [9:0] K_RDN     = 10'b0101111100;
    localparam logic [9:0] K_RDP     = 10'b1010000011;
    localparam int        M_HUNT = 0, M_PAUSE = 1, M_SYNC = 2, M_LINK = 3;
`ifdef JESD_RX_SYSREF_REALIGN_EN
    localparam bit REALIGN_ALL = 1'b1;
`else
    localparam bit REALIGN_ALL = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    jesd204b_rx_slide_ctrl_if rx_if ();

    jesd204b_rx_slide_ctrl #(
        .FRAME_SIZE     (1),
        .FMLC_NUM       (8),
        .SLIDE_WAIT     (32),
        .FMLC_CNT_WIDTH (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .rx_if   (rx_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: posedge index k since reset release, LMFC phase origin t0
    int         k, t0, mode, run, pause_start, rot;
    bit         seen, prev_s;
    bit         e_slide, e_nsync, e_valid, e_aligned, e_lmfc;
    logic [19:0] e_data;

    function automatic bit is_k(input logic [9:0] s);
        return (s == K_RDN) || (s == K_RDP);
    endfunction

    // Periodic {RD+,RD-} stream seen through a receiver misaligned by r bits
    function automatic logic [19:0] comma_word(input int r);
        logic [39:0] d;
        d = {K_RDP, K_RDN, K_RDP, K_RDN};
        d = d >> r;
        return d[19:0];
    endfunction

    function automatic logic [19:0] rand_word();
        logic [19:0] w;
        w = 20'($urandom);
        if (is_k(w[9:0])) w[0] = ~w[0];
        return w;
    endfunction

    task automatic model_reset();
        k = 0; t0 = 0; mode = M_HUNT; run = 0; pause_start = 0;
        seen = 0; prev_s = 0;
        e_slide = 0; e_nsync = 0; e_valid = 0; e_aligned = 0; e_lmfc = 0;
        e_data = '0;
    endtask

    task automatic model_step(input logic [19:0] w, input bit s);
        bit lo, both;
        k++;
        e_slide = 0;
        if (s && !prev_s) begin
            if (REALIGN_ALL || !seen) t0 = k;
            seen = 1;
        end
        prev_s = s;
        e_lmfc = (((k - t0) % LMFC_CLKS) == 0);
        e_data = w;
        lo   = is_k(w[9:0]);
        both = lo && is_k(w[19:10]);
        case (mode)
            M_HUNT: begin
                if (!lo) begin
                    e_slide = 1; run = 0; mode = M_PAUSE; pause_start = k;
                end else if (both) begin
                    run++;
                    if (run == 4) begin run = 0; mode = M_SYNC; e_aligned = 1; end
                end else run = 0;
            end
            M_PAUSE: if (k - pause_start == SLIDE_WAIT) mode = M_HUNT;
            M_SYNC:  if (e_lmfc && seen) begin mode = M_LINK; e_nsync = 1; e_valid = 1; end
            default: begin
                if (both) begin
                    run++;
                    if (run == 4) begin
                        run = 0; mode = M_HUNT; e_nsync = 0; e_valid = 0; e_aligned = 0;
                    end
                end else run = 0;
            end
        endcase
    endtask

    task automatic tick(input logic [19:0] w, input bit s);
        rx_if.i_rx_data = w;
        rx_if.i_sysref  = s;
        @(posedge i_clk);
        model_step(w, s);
        #1;
        check_eq("rxslide",    32'(rx_if.o_rxslide),    32'(e_slide));
        check_eq("nsync",      32'(rx_if.o_nsync),      32'(e_nsync));
        check_eq("data_valid", 32'(rx_if.o_data_valid), 32'(e_valid));
        check_eq("aligned",    32'(rx_if.o_aligned),    32'(e_aligned));
        check_eq("lmfc",       32'(rx_if.o_lmfc),       32'(e_lmfc));
        check_eq("data",       32'(rx_if.o_data),       32'(e_data));
        if (rx_if.o_rxslide) rot = (rot == 0) ? 19 : rot - 1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_nsync"},   32'(rx_if.o_nsync),      32'd0);
        check_eq({tag, "_rxslide"}, 32'(rx_if.o_rxslide),    32'd0);
        check_eq({tag, "_data"},    32'(rx_if.o_data),       32'd0);
        check_eq({tag, "_valid"},   32'(rx_if.o_data_valid), 32'd0);
        check_eq({tag, "_aligned"}, 32'(rx_if.o_aligned),    32'd0);
        check_eq({tag, "_lmfc"},    32'(rx_if.o_lmfc),       32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rx_if.i_sysref = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        rot = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int slides, last_slide, last_lmfc, burst;
        bit s;

        i_rst_n = 1'b0;
        rx_if.i_rx_data = '0;
        rx_if.i_sysref  = 1'b0;
        model_reset();
        rot = 0;
        #3;
        check_reset_vals("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Aligned stream, no SYSREF: aligns, SYNC~ held low
        repeat (60) tick(comma_word(0), 1'b0);
        check_eq("s1_aligned", 32'(rx_if.o_aligned), 32'd1);
        check_eq("s1_nsync",   32'(rx_if.o_nsync),   32'd0);

        // Stream rotated 3 bits: three slides spaced SLIDE_WAIT+1 apart
        do_reset("s2_rst");
        rot = 3; slides = 0; last_slide = -1;
        for (int i = 0; i < 300 && !rx_if.o_aligned; i++) begin
            tick(comma_word(rot), 1'b0);
            if (rx_if.o_rxslide) begin
                if (last_slide >= 0)
                    check_eq("s2_slide_spacing", 32'(k - last_slide), 32'(SLIDE_WAIT + 1));
                last_slide = k;
                slides++;
            end
        end
        check_eq("s2_slides",  32'(slides), 32'd3);
        check_eq("s2_aligned", 32'(rx_if.o_aligned), 32'd1);

        // SYSREF held high 10 cycles: LMFC restarts at once, link comes up with it
        repeat ($urandom_range(7)) tick(comma_word(rot), 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(rand_word(), 1'b1);
            if (i == 0) begin
                check_eq("s3_lmfc_at_edge", 32'(rx_if.o_lmfc),  32'd1);
                check_eq("s3_nsync_up",     32'(rx_if.o_nsync), 32'd1);
            end
        end
        repeat (30) tick(rand_word(), 1'b0);
        check_eq("s3_valid", 32'(rx_if.o_data_valid), 32'd1);

        // Four all-comma words in DATA drop the link
        repeat (4) tick(comma_word(0), 1'b0);
        check_eq("s5_nsync_drop", 32'(rx_if.o_nsync),      32'd0);
        check_eq("s5_valid_drop", 32'(rx_if.o_data_valid), 32'd0);
        for (int i = 0; i < 100 && !rx_if.o_aligned; i++) tick(comma_word(rot), 1'b0);
        for (int i = 0; i < 20 && !rx_if.o_nsync; i++) tick(rand_word(), 1'b0);
        check_eq("s5_relink", 32'(rx_if.o_nsync), 32'd1);
        repeat (5) tick(rand_word(), 1'b0);
        check_eq("s5_in_data", 32'(rx_if.o_data_valid), 32'd1);
        do_reset("s5_mid_data_rst");

        // SYSREF edge while counter sits at its last value: spacing stays 4
        repeat (3) tick(comma_word(0), 1'b0);
        last_lmfc = -1;
        for (int i = 0; i < 16; i++) begin
            tick(comma_word(0), 1'b1);
            if (rx_if.o_lmfc) begin
                if (last_lmfc >= 0) check_eq("s4_lmfc_spacing", 32'(k - last_lmfc), 32'd4);
                last_lmfc = k;
            end
        end

        // Second SYSREF edge offset by 2 cycles from the LMFC phase
        do_reset("s6_rst");
        repeat (5) tick(comma_word(rot), 1'b0);
        repeat (2) tick(comma_word(rot), 1'b1);
        repeat (8) tick(comma_word(rot), 1'b0);
        tick(comma_word(rot), 1'b1);
        check_eq("s6_second_edge_lmfc", 32'(rx_if.o_lmfc), 32'(REALIGN_ALL));
        repeat (12) tick(comma_word(rot), 1'b1);

        // Random soak: misalignment, SYSREF activity, data and comma bursts
        for (int it = 0; it < 6; it++) begin
            do_reset("rnd_rst");
            rot = $urandom_range(4);
            s = 1'b0;
            burst = 0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(15) == 0) s = ~s;
                if (burst == 0 && rx_if.o_aligned && $urandom_range(39) == 0)
                    burst = $urandom_range(3, 5);
                if (burst > 0) begin
                    burst--;
                    tick(comma_word(rot), s);
                end else if (rx_if.o_aligned) begin
                    tick(rand_word(), s);
                end else begin
                    tick(comma_word(rot), s);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
